// File: rtl/key_event.sv
// Two-channel key event generator: turns debounced key levels into one-cycle
// press, release, long-press and auto-repeat pulses timed by a shared tick.
module key_event #(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key_Level,
    output logic [1:0] Press_Pulse,
    output logic [1:0] Release_Pulse,
    output logic [1:0] Long_Pulse,
    output logic [1:0] Repeat_Pulse,
    output logic [1:0] Key_Held
);

    localparam int              PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]     LONG_TH = 16'(LONG_MS);
    localparam logic [15:0]     REP_TH  = 16'(REPEAT_MS);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;

    logic [1:0]    r_lv;
    logic [PW-1:0] r_pre;
    logic          r_tick;

    state_t        r_state    [2];
    logic [15:0]   r_hold_cnt [2];
    logic [15:0]   r_rep_cnt  [2];
    logic [1:0]    r_press;
    logic [1:0]    r_release;
    logic [1:0]    r_long;
    logic [1:0]    r_repeat;
    logic [1:0]    r_held;

    // Tick is registered so a threshold pulse appears one edge after the
    // prescaler terminal count, matching the input-register latency of presses.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            r_lv   <= '0;
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_lv   <= Key_Level;
            r_pre  <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
            r_tick <= (r_pre == PRE_MAX);
        end
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            for (int ch = 0; ch < 2; ch++) begin
                r_state[ch]    <= ST_IDLE;
                r_hold_cnt[ch] <= '0;
                r_rep_cnt[ch]  <= '0;
            end
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
            r_held    <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_press[ch]   <= 1'b0;
                r_release[ch] <= 1'b0;
                r_long[ch]    <= 1'b0;
                r_repeat[ch]  <= 1'b0;
                case (r_state[ch])
                    ST_IDLE: begin
                        if (r_lv[ch]) begin
                            r_press[ch]    <= 1'b1;
                            r_held[ch]     <= 1'b1;
                            r_hold_cnt[ch] <= '0;
                            r_state[ch]    <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        // Release wins over a threshold reached in the same cycle.
                        if (!r_lv[ch]) begin
                            r_release[ch] <= 1'b1;
                            r_held[ch]    <= 1'b0;
                            r_state[ch]   <= ST_IDLE;
                        end else if (r_tick) begin
                            r_hold_cnt[ch] <= r_hold_cnt[ch] + 16'd1;
                            if (r_hold_cnt[ch] + 16'd1 == LONG_TH) begin
                                r_long[ch]    <= 1'b1;
                                r_rep_cnt[ch] <= '0;
                                r_state[ch]   <= ST_REPEAT;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!r_lv[ch]) begin
                            r_release[ch] <= 1'b1;
                            r_held[ch]    <= 1'b0;
                            r_state[ch]   <= ST_IDLE;
                        end else if (r_tick) begin
                            if (r_rep_cnt[ch] + 16'd1 == REP_TH) begin
                                r_repeat[ch]  <= 1'b1;
                                r_rep_cnt[ch] <= '0;
                            end else begin
                                r_rep_cnt[ch] <= r_rep_cnt[ch] + 16'd1;
                            end
                        end
                    end
                    default: begin
                        r_held[ch]  <= 1'b0;
                        r_state[ch] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Press_Pulse   = r_press;
    assign Release_Pulse = r_release;
    assign Long_Pulse    = r_long;
    assign Repeat_Pulse  = r_repeat;
    assign Key_Held      = r_held;

endmodule
